// File: rtl/nios_ocimem_pkg.sv
// Shared types and jdo field positions for the OCI debug-memory controller.
package nios_ocimem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_J_RD = 2'd1,
        ST_J_WR = 2'd2,
        ST_C_RD = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_RD   = 2'd1,
        PEND_WR   = 2'd2
    } pend_e;

    localparam int JDO_W         = 38;
    localparam int JDO_ADDR_LSB  = 9;
    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_RD_BIT    = 35;

endpackage

// File: rtl/nios_ocimem_ram.sv
// Single-port DEPTH x 32 debug RAM with byte-lane write enables and registered read.
// Addresses at or above DEPTH read as zero and are never written.
module nios_ocimem_ram #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [3:0]        i_be,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_q
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    logic [31:0]      r_mem [DEPTH];
    logic [31:0]      r_q;
    logic             w_in_range;
    logic [IDX_W-1:0] w_idx;

    assign w_in_range = {1'b0, i_addr} < DEPTH_LIM;
    assign w_idx      = i_addr[IDX_W-1:0];
    assign o_q        = r_q;

    always_ff @(posedge clk) begin
        if (w_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
            r_q <= r_mem[w_idx];
        end else begin
            r_q <= '0;
        end
    end

endmodule

// File: rtl/nios_ocimem_ctrl.sv
// OCI debug-memory controller: JTAG commands from the debug module and a CPU
// Avalon-MM slave share one RAM, JTAG first. NIOS_OCIMEM_BYTEEN_EN enables CPU byte lanes.
module nios_ocimem_ctrl
    import nios_ocimem_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [31:0]       av_writedata,
    input  logic [3:0]        av_byteenable,
    output logic [31:0]       av_readdata,
    output logic              av_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic [1:0]        o_dbg_state,
    output logic [ADDR_W-1:0] o_dbg_mon_a
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    state_e            r_state;
    state_e            w_state_nxt;
    pend_e             r_pend;
    logic [ADDR_W-1:0] r_mon_a;
    logic [31:0]       r_mon_d;
    logic              r_ready;
    logic              r_error;
    logic              r_aload_done;
    logic              r_rd_oor;

    logic [ADDR_W-1:0] w_jdo_addr;
    logic [31:0]       w_jdo_wdata;
    logic              w_pulse;
    logic              w_cpu_ok;
    logic              w_mon_a_in_range;
    logic [3:0]        w_cpu_be;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [3:0]        w_ram_be;
    logic [31:0]       w_ram_wdata;
    logic [31:0]       w_ram_q;
    logic              w_pend_clr;
    logic              w_jrd_issue;
    logic              w_unused;

    assign w_jdo_addr       = jdo[JDO_ADDR_LSB +: ADDR_W];
    assign w_jdo_wdata      = jdo[JDO_WDATA_LSB +: 32];
    assign w_pulse          = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign w_mon_a_in_range = {1'b0, r_mon_a} < DEPTH_LIM;
    // CPU only gets the RAM on a cycle with no JTAG work queued or arriving.
    assign w_cpu_ok         = (r_state == ST_IDLE) && (r_pend == PEND_NONE) && !w_pulse && !reset;

`ifdef NIOS_OCIMEM_BYTEEN_EN
    assign w_cpu_be = av_byteenable;
    assign w_unused = ^{jdo[JDO_WDATA_LSB-1:0], jdo[37:36]};
`else
    assign w_cpu_be = 4'hF;
    assign w_unused = ^{jdo[JDO_WDATA_LSB-1:0], jdo[37:36], av_byteenable};
`endif

    // Reads complete only in C_RD; writes complete on any free IDLE cycle.
    assign av_waitrequest = av_read ? (r_state != ST_C_RD) : (av_write & !w_cpu_ok);
    assign av_readdata    = (r_state == ST_C_RD) ? w_ram_q : '0;
    assign MonDReg        = r_mon_d;
    assign monitor_ready  = r_ready;
    assign monitor_error  = r_error;
    assign o_dbg_state    = r_state;
    assign o_dbg_mon_a    = r_mon_a;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ram_addr  = r_mon_a;
        w_ram_be    = 4'h0;
        w_ram_wdata = av_writedata;
        w_pend_clr  = 1'b0;
        w_jrd_issue = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pend == PEND_RD) begin
                    w_jrd_issue = 1'b1;
                    w_pend_clr  = 1'b1;
                    w_state_nxt = ST_J_RD;
                end else if (r_pend == PEND_WR) begin
                    w_pend_clr  = 1'b1;
                    w_state_nxt = ST_J_WR;
                end else if (av_read && w_cpu_ok) begin
                    w_ram_addr  = av_address;
                    w_state_nxt = ST_C_RD;
                end else if (av_write && w_cpu_ok) begin
                    w_ram_addr  = av_address;
                    w_ram_be    = w_cpu_be;
                end
            end
            ST_J_RD: w_state_nxt = ST_IDLE;
            ST_J_WR: begin
                w_ram_be    = 4'hF;
                w_ram_wdata = r_mon_d;
                w_state_nxt = ST_IDLE;
            end
            ST_C_RD: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Command pulses are applied last so the newest JTAG command wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend       <= PEND_NONE;
            r_mon_a      <= '0;
            r_mon_d      <= '0;
            r_ready      <= 1'b1;
            r_error      <= 1'b0;
            r_aload_done <= 1'b0;
            r_rd_oor     <= 1'b0;
        end else begin
            r_aload_done <= take_action_ocimem_a & ~jdo[JDO_RD_BIT];
            if (w_jrd_issue) begin
                r_rd_oor <= ~w_mon_a_in_range;
            end
            if (w_pend_clr) begin
                r_pend <= PEND_NONE;
            end
            if (r_state == ST_J_RD) begin
                r_mon_d <= w_ram_q;
                r_mon_a <= r_mon_a + 1'b1;
                r_ready <= 1'b1;
                if (r_rd_oor) begin
                    r_error <= 1'b1;
                end
            end
            if (r_state == ST_J_WR) begin
                r_mon_a <= r_mon_a + 1'b1;
                r_ready <= 1'b1;
                if (!w_mon_a_in_range) begin
                    r_error <= 1'b1;
                end
            end
            if (r_aload_done) begin
                r_ready <= 1'b1;
            end
            if (take_action_ocimem_a) begin
                r_mon_a <= w_jdo_addr;
                r_error <= 1'b0;
                r_ready <= 1'b0;
                r_pend  <= jdo[JDO_RD_BIT] ? PEND_RD : PEND_NONE;
            end
            if (take_no_action_ocimem_a) begin
                r_pend  <= PEND_RD;
                r_ready <= 1'b0;
            end
            if (take_action_ocimem_b) begin
                r_mon_d <= w_jdo_wdata;
                r_pend  <= PEND_WR;
                r_ready <= 1'b0;
            end
        end
    end

    nios_ocimem_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_addr  (w_ram_addr),
        .i_be    (reset ? 4'h0 : w_ram_be),
        .i_wdata (w_ram_wdata),
        .o_q     (w_ram_q)
    );

endmodule

// File: tb/tb_nios_ocimem_ctrl.sv
// Bench for nios_ocimem_ctrl: directed scenarios then random JTAG/CPU traffic
// checked against a transaction-level memory model.
module tb_nios_ocimem_ctrl;
    import nios_ocimem_pkg::*;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 256;
    localparam int SPACE  = 512;

    logic              clk = 1'b0;
    logic              reset;
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              take_no_action_ocimem_a;
    logic [ADDR_W-1:0] av_address;
    logic              av_read;
    logic              av_write;
    logic [31:0]       av_writedata;
    logic [3:0]        av_byteenable;
    logic [31:0]       av_readdata;
    logic              av_waitrequest;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;
    logic [1:0]        o_dbg_state;
    logic [ADDR_W-1:0] o_dbg_mon_a;

    // model state
    logic [31:0] mem_m [DEPTH];
    int          m_mon_a;
    logic [31:0] m_mon_d;
    logic        m_err;
    logic [31:0] exp_q[$];

    int n_asserts = 0;
    int n_fail    = 0;

    nios_ocimem_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .av_address              (av_address),
        .av_read                 (av_read),
        .av_write                (av_write),
        .av_writedata            (av_writedata),
        .av_byteenable           (av_byteenable),
        .av_readdata             (av_readdata),
        .av_waitrequest          (av_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .o_dbg_state             (o_dbg_state),
        .o_dbg_mon_a             (o_dbg_mon_a)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_rd(input int a);
        return (a < DEPTH) ? mem_m[a] : 32'h0;
    endfunction

    task automatic check_jtag_regs(input string tag);
        check({tag, "_ready"}, 32'(monitor_ready), 32'd1);
        check({tag, "_mond"},  MonDReg, m_mon_d);
        check({tag, "_err"},   32'(monitor_error), 32'(m_err));
        check({tag, "_mona"},  32'(o_dbg_mon_a), 32'(m_mon_a));
    endtask

    // Pulse sits in cycle N; result is visible in N+3.
    task automatic jtag_finish(input string tag);
        @(negedge clk);
        check({tag, "_busy"}, 32'(monitor_ready), 32'd0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_jtag_regs(tag);
        next_cycle();
    endtask

    task automatic jtag_load_read(input int addr);
        jdo = '0;
        jdo[17:9] = addr[8:0];
        jdo[35] = 1'b1;
        take_action_ocimem_a = 1'b1;
        next_cycle();
        take_action_ocimem_a = 1'b0;
        m_err   = (addr >= DEPTH);
        m_mon_d = m_rd(addr);
        m_mon_a = (addr + 1) % SPACE;
        jtag_finish("jrd");
    endtask

    task automatic jtag_write(input logic [31:0] data);
        jdo = '0;
        jdo[34:3] = data;
        take_action_ocimem_b = 1'b1;
        next_cycle();
        take_action_ocimem_b = 1'b0;
        if (m_mon_a < DEPTH) mem_m[m_mon_a] = data;
        else m_err = 1'b1;
        m_mon_d = data;
        m_mon_a = (m_mon_a + 1) % SPACE;
        jtag_finish("jwr");
    endtask

    task automatic jtag_stream_read();
        take_no_action_ocimem_a = 1'b1;
        next_cycle();
        take_no_action_ocimem_a = 1'b0;
        m_mon_d = m_rd(m_mon_a);
        if (m_mon_a >= DEPTH) m_err = 1'b1;
        m_mon_a = (m_mon_a + 1) % SPACE;
        jtag_finish("jstr");
    endtask

    // Address-only load: ready returns in N+2.
    task automatic jtag_addr_load(input int addr);
        jdo = '0;
        jdo[17:9] = addr[8:0];
        take_action_ocimem_a = 1'b1;
        next_cycle();
        take_action_ocimem_a = 1'b0;
        m_mon_a = addr;
        m_err   = 1'b0;
        @(negedge clk);
        check("aload_busy", 32'(monitor_ready), 32'd0);
        next_cycle();
        @(negedge clk);
        check_jtag_regs("aload");
        next_cycle();
    endtask

    task automatic cpu_write(input int a, input logic [31:0] d, input logic [3:0] be);
        int n;
        logic [3:0] lanes;
        av_address    = a[8:0];
        av_writedata  = d;
        av_byteenable = be;
        av_write      = 1'b1;
        n = 0;
        @(negedge clk);
        while (av_waitrequest && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("cpu_wr_wait", 32'(av_waitrequest), 32'd0);
        check("cpu_wr_lat", n, 0);
        next_cycle();
        av_write = 1'b0;
`ifdef NIOS_OCIMEM_BYTEEN_EN
        lanes = be;
`else
        lanes = 4'hF;
`endif
        if (a < DEPTH) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes[i]) mem_m[a][8*i +: 8] = d[8*i +: 8];
            end
        end
    endtask

    task automatic cpu_read(input int a, output logic [31:0] d);
        int n;
        exp_q.push_back(m_rd(a));
        av_address = a[8:0];
        av_read    = 1'b1;
        @(negedge clk);
        check("cpu_rd_w1", 32'(av_waitrequest), 32'd1);
        n = 1;
        while (av_waitrequest && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("cpu_rd_lat", n, 2);
        d = av_readdata;
        check("cpu_rd_data", av_readdata, exp_q.pop_front());
        next_cycle();
        av_read = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int n;
        int op;

        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        av_address = '0;
        av_read = 1'b0;
        av_write = 1'b0;
        av_writedata = '0;
        av_byteenable = 4'h0;
        m_mon_a = 0;
        m_mon_d = '0;
        m_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(monitor_ready), 32'd1);
        check("rst_err",   32'(monitor_error), 32'd0);
        check("rst_mond",  MonDReg, 32'h0);
        check("rst_rdata", av_readdata, 32'h0);
        check("rst_wait",  32'(av_waitrequest), 32'd0);
        check("rst_mona",  32'(o_dbg_mon_a), 32'd0);
        check("rst_state", 32'(o_dbg_state), 32'(ST_IDLE));
        next_cycle();

        for (int i = 0; i < DEPTH; i++) cpu_write(i, $urandom, 4'hF);

        // address-load read
        cpu_write(5, 32'hDEADBEEF, 4'hF);
        jtag_load_read(5);
        check("aload_rd_val", MonDReg, 32'hDEADBEEF);
        check("aload_rd_mona", 32'(o_dbg_mon_a), 32'd6);

        // streaming write then read
        jtag_addr_load(32'h10);
        jtag_write(32'h11111111);
        jtag_write(32'h22222222);
        jtag_load_read(32'h10);
        check("stream_rd1", MonDReg, 32'h11111111);
        jtag_stream_read();
        check("stream_rd2", MonDReg, 32'h22222222);

        // wrap and error
        jtag_addr_load(511);
        jtag_write(32'hA5A5A5A5);
        check("wrap_err", 32'(monitor_error), 32'd1);
        check("wrap_mona", 32'(o_dbg_mon_a), 32'd0);
        cpu_read(255, rd);
        cpu_read(511, rd);
        check("oor_cpu_rd", rd, 32'h0);
        jtag_addr_load(0);
        check("err_cleared", 32'(monitor_error), 32'd0);

        // arbitration: CPU read coincident with a JTAG read pulse
        cpu_write(3, 32'h0BADCAFE, 4'hF);
        jdo = '0;
        jdo[17:9] = 9'd5;
        jdo[35] = 1'b1;
        take_action_ocimem_a = 1'b1;
        av_address = 9'd3;
        av_read = 1'b1;
        m_mon_d = mem_m[5];
        m_mon_a = 6;
        m_err = 1'b0;
        @(negedge clk);
        check("arb_w0", 32'(av_waitrequest), 32'd1);
        next_cycle();
        take_action_ocimem_a = 1'b0;
        n = 1;
        @(negedge clk);
        while (av_waitrequest && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("arb_wait_cycles", n, 4);
        check("arb_cpu_data", av_readdata, 32'h0BADCAFE);
        check_jtag_regs("arb_jtag");
        next_cycle();
        av_read = 1'b0;

        // byte enables
        cpu_write(0, 32'hFFFFFFFF, 4'hF);
        cpu_write(0, 32'h12345678, 4'b0011);
        cpu_read(0, rd);
`ifdef NIOS_OCIMEM_BYTEEN_EN
        check("byteen_word0", rd, 32'hFFFF5678);
`else
        check("byteen_word0", rd, 32'h12345678);
`endif

        // reset in the cycle after a write pulse
        cpu_write(32'h20, 32'hCAFEF00D, 4'hF);
        jtag_addr_load(32'h20);
        jdo = '0;
        jdo[34:3] = 32'h5555AAAA;
        take_action_ocimem_b = 1'b1;
        next_cycle();
        take_action_ocimem_b = 1'b0;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        m_mon_a = 0;
        m_mon_d = '0;
        m_err = 1'b0;
        @(negedge clk);
        check_jtag_regs("rst_mid");
        next_cycle();
        cpu_read(32'h20, rd);
        check("rst_mid_ram", rd, 32'hCAFEF00D);

        // random mixed traffic
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: cpu_write($urandom_range(0, 300), $urandom, 4'($urandom_range(0, 15)));
                1: cpu_read($urandom_range(0, 300), rd);
                2: jtag_load_read($urandom_range(0, 300));
                3: jtag_write($urandom);
                default: jtag_stream_read();
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
